// File: rtl/nes_stream_pkg.sv
// Shared types and helpers for the NES PPU -> VGA pixel stream path.
// Optional feature macro used by this slice: NES_LINE_DOUBLE_EN (see nes_line_sched).
package nes_stream_pkg;

    localparam int NES_IDX_W  = 6;
    localparam int NES_LINE_W = 256;
    localparam int NES_OUT_W  = 8;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // VGA byte layout: valid flag in the MSB, palette index in the LSBs, zeros between.
    function automatic logic [NES_OUT_W-1:0] pack_pix(input logic valid, input logic [NES_IDX_W-1:0] idx);
        return {valid, {(NES_OUT_W-NES_IDX_W-1){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/nes_line_ram.sv
// Two-bank line buffer storage: one write port, one registered read port.
// The read register only updates on rd_en, so the last pixel read is held.
module nes_line_ram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 6,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/nes_line_sched.sv
// Ping-pong line scheduler between the PPU pixel stream and the VGA pixel stream.
// Define NES_LINE_DOUBLE_EN to drain every full bank twice (240 -> 480 line doubling).
module nes_line_sched
    import nes_stream_pkg::*;
#(
    parameter int LINE_W = NES_LINE_W,
    parameter int IDX_W  = NES_IDX_W,
    parameter int OUT_W  = NES_OUT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ppu_pix_valid,
    input  logic [IDX_W-1:0] ppu_pix_idx,
    input  logic             ppu_line_end,
    input  logic             vga_stream_read,
    output logic [OUT_W-1:0] vga_stream_out,
    output logic             ppu_overflow,
    output logic             vga_underrun,
    output logic [3:0]       bank_state
);

    localparam int PTR_W = $clog2(LINE_W);
    localparam int LEN_W = PTR_W + 1;

    bank_state_e      bank_st [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] len [2];
    logic             dropping;
    logic             out_valid;
    logic [IDX_W-1:0] ram_q;
`ifdef NES_LINE_DOUBLE_EN
    logic             pass;
`endif

    logic wr_ok;
    logic wr_accept;
    logic wr_done;
    logic wr_close;
    logic rd_ok;
    logic rd_accept;
    logic rd_last;

    always_comb begin
        wr_ok     = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
        wr_accept = ppu_pix_valid && wr_ok && !dropping;
        wr_done   = wr_accept && ((wr_ptr == PTR_W'(LINE_W-1)) || ppu_line_end);
        wr_close  = !wr_accept && ppu_line_end && (bank_st[wr_bank] == FILLING);
        rd_ok     = (bank_st[rd_bank] == FULL) || (bank_st[rd_bank] == DRAINING);
        rd_accept = vga_stream_read && rd_ok;
        rd_last   = ({1'b0, rd_ptr} == (len[rd_bank] - LEN_W'(1)));
    end

    // Writer and reader never own the same bank at once, so their bank_st updates never collide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_st[0]   <= EMPTY;
            bank_st[1]   <= EMPTY;
            len[0]       <= '0;
            len[1]       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            dropping     <= 1'b0;
            out_valid    <= 1'b0;
            ppu_overflow <= 1'b0;
            vga_underrun <= 1'b0;
`ifdef NES_LINE_DOUBLE_EN
            pass         <= 1'b0;
`endif
        end else begin
            ppu_overflow <= 1'b0;
            vga_underrun <= 1'b0;

            if (wr_done) begin
                bank_st[wr_bank] <= FULL;
                len[wr_bank]     <= {1'b0, wr_ptr} + LEN_W'(1);
                wr_ptr           <= '0;
                wr_bank          <= ~wr_bank;
            end else if (wr_accept) begin
                bank_st[wr_bank] <= FILLING;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end else if (wr_close) begin
                bank_st[wr_bank] <= FULL;
                len[wr_bank]     <= {1'b0, wr_ptr};
                wr_ptr           <= '0;
                wr_bank          <= ~wr_bank;
            end

            // Only the first dropped pixel of a line is reported; line_end re-arms.
            if (ppu_pix_valid && !wr_ok && !dropping)
                ppu_overflow <= 1'b1;
            if (ppu_line_end)
                dropping <= 1'b0;
            else if (ppu_pix_valid && !wr_ok)
                dropping <= 1'b1;

            if (rd_accept) begin
                out_valid <= 1'b1;
                if (rd_last) begin
                    rd_ptr <= '0;
`ifdef NES_LINE_DOUBLE_EN
                    if (!pass) begin
                        pass             <= 1'b1;
                        bank_st[rd_bank] <= DRAINING;
                    end else begin
                        pass             <= 1'b0;
                        bank_st[rd_bank] <= EMPTY;
                        rd_bank          <= ~rd_bank;
                    end
`else
                    bank_st[rd_bank] <= EMPTY;
                    rd_bank          <= ~rd_bank;
`endif
                end else begin
                    rd_ptr           <= rd_ptr + PTR_W'(1);
                    bank_st[rd_bank] <= DRAINING;
                end
            end else if (vga_stream_read) begin
                out_valid    <= 1'b0;
                vga_underrun <= 1'b1;
            end
        end
    end

    nes_line_ram #(
        .DEPTH (2*LINE_W),
        .WIDTH (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr ({wr_bank, wr_ptr}),
        .wr_data (ppu_pix_idx),
        .rd_en   (rd_accept),
        .rd_addr ({rd_bank, rd_ptr}),
        .rd_data (ram_q)
    );

    assign bank_state     = {bank_st[1], bank_st[0]};
    assign vga_stream_out = pack_pix(out_valid, out_valid ? ram_q : '0);

endmodule

// File: tb/tb_nes_line_sched.sv
// Directed self-checking bench for nes_line_sched; follows NES_LINE_DOUBLE_EN when defined.
module tb_nes_line_sched;

`ifdef NES_LINE_DOUBLE_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ppu_pix_valid = 1'b0;
    logic [5:0] ppu_pix_idx = '0;
    logic       ppu_line_end = 1'b0;
    logic       vga_stream_read = 1'b0;
    logic [7:0] vga_stream_out;
    logic       ppu_overflow;
    logic       vga_underrun;
    logic [3:0] bank_state;

    int checkCount = 0;
    int errorCount = 0;
    int ovfCount = 0;
    int undCount = 0;

    always #5 clk = ~clk;

    nes_line_sched dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ppu_pix_valid   (ppu_pix_valid),
        .ppu_pix_idx     (ppu_pix_idx),
        .ppu_line_end    (ppu_line_end),
        .vga_stream_read (vga_stream_read),
        .vga_stream_out  (vga_stream_out),
        .ppu_overflow    (ppu_overflow),
        .vga_underrun    (vga_underrun),
        .bank_state      (bank_state)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle of stimulus; outputs are settled on return.
    task automatic applyStimulus(input logic valid, input logic [5:0] idx, input logic lineEnd, input logic rd);
        @(negedge clk);
        ppu_pix_valid   = valid;
        ppu_pix_idx     = idx;
        ppu_line_end    = lineEnd;
        vga_stream_read = rd;
        @(posedge clk);
        #1;
        ovfCount += int'(ppu_overflow);
        undCount += int'(vga_underrun);
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        reset_n         = 1'b0;
        ppu_pix_valid   = 1'b0;
        ppu_line_end    = 1'b0;
        vga_stream_read = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        ovfCount = 0;
        undCount = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic writeLine(input int n, input int base, input logic endWithLast);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 6'((base + i) & 63), endWithLast && (i == n-1), 1'b0);
        if (!endWithLast)
            applyStimulus(1'b0, 6'd0, 1'b1, 1'b0);
    endtask

    task automatic readCheck(input string tag, input int n, input int base);
        for (int p = 0; p < PASSES; p++)
            for (int i = 0; i < n; i++) begin
                applyStimulus(1'b0, 6'd0, 1'b0, 1'b1);
                checkOutput(tag, 32'(vga_stream_out), 32'(8'h80 | ((base + i) & 63)));
            end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        doReset(2);
        checkOutput("rst_bank_state", 32'(bank_state), 32'h0);
        checkOutput("rst_out", 32'(vga_stream_out), 32'h0);
        checkOutput("rst_overflow", 32'(ppu_overflow), 32'h0);
        checkOutput("rst_underrun", 32'(vga_underrun), 32'h0);

        // T1: full-width line fill and drain
        applyStimulus(1'b1, 6'd0, 1'b0, 1'b0);
        checkOutput("t1_filling", 32'(bank_state), 32'h1);
        for (int i = 1; i < 256; i++)
            applyStimulus(1'b1, 6'(i & 63), 1'b0, 1'b0);
        checkOutput("t1_full", 32'(bank_state), 32'h2);
        readCheck("t1_data", 256, 0);
        checkOutput("t1_empty", 32'(bank_state), 32'h0);
        checkOutput("t1_no_underrun", 32'(undCount), 32'd0);

        // T2: short line closed by a separate line_end, then underrun on the empty bank
        doReset(1);
        writeLine(10, 5, 1'b0);
        checkOutput("t2_full", 32'(bank_state), 32'h2);
        readCheck("t2_data", 10, 5);
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b1);
        checkOutput("t2_underrun_out", 32'(vga_stream_out), 32'h0);
        checkOutput("t2_underrun_pulse", 32'(vga_underrun), 32'h1);
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("t2_underrun_once", 32'(undCount), 32'd1);
        checkOutput("t2_hold_out", 32'(vga_stream_out), 32'h0);
        // line_end coinciding with the last pixel lands in bank1
        writeLine(3, 20, 1'b1);
        checkOutput("t2b_bank1_full", 32'(bank_state), 32'h8);
        readCheck("t2b_data", 3, 20);
        checkOutput("t2b_empty", 32'(bank_state), 32'h0);

        // T3: overflow with both banks full, single pulse, re-arm on next line
        doReset(1);
        for (int i = 0; i < 512; i++)
            applyStimulus(1'b1, 6'(i & 63), 1'b0, 1'b0);
        checkOutput("t3_both_full", 32'(bank_state), 32'hA);
        applyStimulus(1'b1, 6'd1, 1'b0, 1'b0);
        checkOutput("t3_ovf_pulse", 32'(ppu_overflow), 32'h1);
        applyStimulus(1'b1, 6'd2, 1'b0, 1'b0);
        checkOutput("t3_ovf_single", 32'(ppu_overflow), 32'h0);
        applyStimulus(1'b1, 6'd3, 1'b0, 1'b0);
        checkOutput("t3_ovf_count", 32'(ovfCount), 32'd1);
        checkOutput("t3_state_kept", 32'(bank_state), 32'hA);
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd4, 1'b0, 1'b0);
        checkOutput("t3_rearm", 32'(ovfCount), 32'd2);
        readCheck("t3_bank0_data", 256, 0);

        // T4: short line, doubled when the feature is enabled
        doReset(1);
        writeLine(4, 1, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b1);
        checkOutput("t4_first", 32'(vga_stream_out), 32'h81);
        checkOutput("t4_draining", 32'(bank_state), 32'h3);
        for (int i = 1; i < 4*PASSES; i++) begin
            applyStimulus(1'b0, 6'd0, 1'b0, 1'b1);
            checkOutput("t4_data", 32'(vga_stream_out), 32'(8'h81 + (i % 4)));
        end
        checkOutput("t4_empty", 32'(bank_state), 32'h0);

        // T5: concurrent write of line k+1 while line k drains
        doReset(1);
        writeLine(8, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < ((8*PASSES > 9) ? 8*PASSES : 9); c++) begin
                applyStimulus(c < 8, 6'(((k+1)*8 + c) & 63), c == 8, c < 8*PASSES);
                if (c < 8*PASSES)
                    checkOutput("t5_data", 32'(vga_stream_out), 32'(8'h80 | ((k*8 + (c % 8)) & 63)));
            end
        end
        readCheck("t5_tail", 8, 32);
        checkOutput("t5_no_overflow", 32'(ovfCount), 32'd0);
        checkOutput("t5_no_underrun", 32'(undCount), 32'd0);
        checkOutput("t5_empty", 32'(bank_state), 32'h0);

        // T6: reset in the middle of a fill discards everything
        doReset(1);
        writeLine(4, 50, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b1);
        checkOutput("t6_pre_out", 32'(vga_stream_out), 32'hB2);
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, 6'(i & 63), 1'b0, 1'b0);
        checkOutput("t6_pre_state", 32'(bank_state), 32'h7);
        doReset(1);
        checkOutput("t6_rst_state", 32'(bank_state), 32'h0);
        checkOutput("t6_rst_out", 32'(vga_stream_out), 32'h0);
        checkOutput("t6_rst_pulses", 32'({ppu_overflow, vga_underrun}), 32'h0);
        writeLine(4, 7, 1'b0);
        checkOutput("t6_bank0_full", 32'(bank_state), 32'h2);
        readCheck("t6_data", 4, 7);
        checkOutput("t6_no_underrun", 32'(undCount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
